// File: rtl/note_pkg.sv
// Shared definitions for the melody player: note codes, pitch table and FSM states.
package note_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_TONE  = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    localparam logic [3:0] NOTE_REST = 4'h0;
    localparam logic [3:0] NOTE_C4   = 4'h1;
    localparam logic [3:0] NOTE_D4   = 4'h2;
    localparam logic [3:0] NOTE_E4   = 4'h3;
    localparam logic [3:0] NOTE_F4   = 4'h4;
    localparam logic [3:0] NOTE_G4   = 4'h5;
    localparam logic [3:0] NOTE_A4   = 4'h6;
    localparam logic [3:0] NOTE_B4   = 4'h7;
    localparam logic [3:0] NOTE_C5   = 4'h8;
    localparam logic [3:0] NOTE_END  = 4'hF;

    // Pitch in Hz for codes C4..C5, indexed by (code - 1).
    localparam int unsigned FREQ_TABLE [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

    // Half-period count for a divider that toggles once its counter reaches the limit.
    function automatic logic [31:0] div_for(input int unsigned clk_hz, input int unsigned f);
        return 32'((clk_hz / (2 * f)) - 1);
    endfunction

endpackage

// File: rtl/note_table.sv
// Note storage: one write port and one registered read port with read-before-write behaviour.
module note_table #(
    parameter int unsigned DEPTH = 32
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     rd_en_i,
    input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
    output logic [7:0]               rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // Both updates are non-blocking, so a same-address read sees the old entry.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/note_sequencer.sv
// Steps through the note table, converting each entry into a divider count held for its
// beat length, followed by a silent gap with the divider held in reset.
module note_sequencer
    import note_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned BEAT_CYCLES = 12_500_000,
    parameter int unsigned GAP_CYCLES  = 1_250_000,
    parameter int unsigned DEPTH       = 32
) (
    input  logic                     inclk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     loop_en,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [7:0]               wr_data,
    output logic [31:0]              div_count,
    output logic                     div_reset,
    output logic                     playing,
    output logic [$clog2(DEPTH)-1:0] note_idx,
    output logic                     done,
    output state_t                   dbg_state
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [31:0] GAP_LOAD = 32'(GAP_CYCLES - 1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    localparam logic [31:0] DIV_TAB [8] = '{
        div_for(CLK_HZ, FREQ_TABLE[0]), div_for(CLK_HZ, FREQ_TABLE[1]),
        div_for(CLK_HZ, FREQ_TABLE[2]), div_for(CLK_HZ, FREQ_TABLE[3]),
        div_for(CLK_HZ, FREQ_TABLE[4]), div_for(CLK_HZ, FREQ_TABLE[5]),
        div_for(CLK_HZ, FREQ_TABLE[6]), div_for(CLK_HZ, FREQ_TABLE[7])
    };

    state_t          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            wrap_q, wrap_d;
    logic [31:0]     timer_q, timer_d;
    logic [31:0]     div_q, div_d;
    logic            rest_q, rest_d;
    logic            done_q, done_d;

    logic [7:0]      rd_data;
    logic [3:0]      entry_note;
    logic [3:0]      entry_beats;
    logic            entry_pitched;
    logic [31:0]     beat_len;
    logic [31:0]     entry_div;

    note_table #(
        .DEPTH(DEPTH)
    ) u_table (
        .clk_i    (inclk),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .rd_en_i  (state_q == S_FETCH),
        .rd_addr_i(idx_q),
        .rd_data_o(rd_data)
    );

    // Codes 9..14 fall outside 1..8 and therefore decode as rests.
    always_comb begin
        entry_note    = rd_data[7:4];
        entry_beats   = (rd_data[3:0] == 4'd0) ? 4'd1 : rd_data[3:0];
        entry_pitched = (entry_note != NOTE_REST) && (entry_note <= NOTE_C5);
        beat_len      = {28'd0, entry_beats} * BEAT_CYCLES;
        entry_div     = entry_pitched ? DIV_TAB[3'(entry_note - 4'd1)] : 32'd0;
    end

    // start and stop are single-cycle strobes with no acknowledge: start is accepted only
    // in IDLE, and stop wins over everything else in any other state.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = wrap_q;
        timer_d = timer_q;
        div_d   = div_q;
        rest_d  = rest_q;
        done_d  = 1'b0;

        if (stop && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !stop) begin
                        state_d = S_FETCH;
                        idx_d   = '0;
                        wrap_d  = 1'b0;
                    end
                end
                S_FETCH: begin
                    state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (wrap_q || (entry_note == NOTE_END)) begin
                        if (loop_en) begin
                            state_d = S_FETCH;
                            idx_d   = '0;
                            wrap_d  = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        div_d   = entry_div;
                        rest_d  = !entry_pitched;
                        timer_d = beat_len - 32'd1;
                        state_d = S_TONE;
                    end
                end
                S_TONE: begin
                    if (timer_q == 32'd0) begin
                        timer_d = GAP_LOAD;
                        state_d = S_GAP;
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                S_GAP: begin
                    if (timer_q == 32'd0) begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                        // Running off the end of the table ends the melody like an END code.
                        if (idx_q == LAST_IDX) begin
                            wrap_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q - 32'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            timer_q <= 32'd0;
            div_q   <= 32'd0;
            rest_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            timer_q <= timer_d;
            div_q   <= div_d;
            rest_q  <= rest_d;
            done_q  <= done_d;
        end
    end

    assign div_count = div_q;
    assign div_reset = !((state_q == S_TONE) && !rest_q);
    assign playing   = (state_q != S_IDLE);
    assign note_idx  = idx_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench: a melody-level model expands each playback into the expected
// per-cycle output trace, and a monitor compares the DUT against it cycle by cycle.
module tb_note_sequencer;
    import note_pkg::*;

    localparam int unsigned CLK_HZ = 50_000_000;
    localparam int unsigned BEAT   = 10;
    localparam int unsigned GAP    = 2;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned AW     = 3;
    localparam int unsigned EW     = 38;

    logic           inclk   = 1'b0;
    logic           reset   = 1'b1;
    logic           start   = 1'b0;
    logic           stop    = 1'b0;
    logic           loop_en = 1'b0;
    logic           wr_en   = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [7:0]     wr_data = '0;
    logic [31:0]    div_count;
    logic           div_reset;
    logic           playing;
    logic [AW-1:0]  note_idx;
    logic           done;
    state_t         dbg_state;

    always #5 inclk = ~inclk;

    note_sequencer #(
        .CLK_HZ(CLK_HZ), .BEAT_CYCLES(BEAT), .GAP_CYCLES(GAP), .DEPTH(DEPTH)
    ) dut (
        .inclk(inclk), .reset(reset), .start(start), .stop(stop), .loop_en(loop_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .div_count(div_count), .div_reset(div_reset), .playing(playing),
        .note_idx(note_idx), .done(done), .dbg_state(dbg_state)
    );

    // Expected word: {playing, div_reset, div_count[31:0], note_idx[2:0], done}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] tr_q[$];
    logic [7:0]    tbl_m [DEPTH];
    logic [31:0]   m_div = 32'd0;
    int            m_idx = 0;
    int            vectors = 0;
    int            miscompares = 0;
    string         cur_test = "reset";
    int unsigned   freq_hz [8] = '{262, 294, 330, 349, 392, 440, 494, 523};

    function automatic logic [EW-1:0] ev(input bit p, input bit r, input logic [31:0] d,
                                         input int i, input bit dn);
        return {p, r, d, 3'(i), dn};
    endfunction

    function automatic logic [31:0] model_div(input logic [3:0] nt);
        if (nt >= 4'd1 && nt <= 4'd8) return 32'(CLK_HZ / (2 * freq_hz[nt - 4'd1]) - 1);
        return 32'd0;
    endfunction

    // Expands the melody in tbl_m into one expected word per clock after start is taken.
    function automatic void build_trace(input bit lp, input int limit);
        int          idx;
        bit          wrapped;
        logic [31:0] div;
        logic [3:0]  nt;
        logic [3:0]  bt;
        bit          pitched;
        int          len;
        tr_q.delete();
        idx = 0;
        wrapped = 0;
        div = m_div;
        while (tr_q.size() < limit) begin
            tr_q.push_back(ev(1, 1, div, idx, 0));
            tr_q.push_back(ev(1, 1, div, idx, 0));
            nt = tbl_m[idx][7:4];
            bt = tbl_m[idx][3:0];
            if (wrapped || nt == 4'hF) begin
                if (lp) begin
                    idx = 0;
                    wrapped = 0;
                    continue;
                end
                tr_q.push_back(ev(0, 1, div, idx, 1));
                tr_q.push_back(ev(0, 1, div, idx, 0));
                tr_q.push_back(ev(0, 1, div, idx, 0));
                break;
            end
            pitched = (nt >= 4'd1 && nt <= 4'd8);
            div = model_div(nt);
            len = ((bt == 4'd0) ? 1 : int'(bt)) * BEAT;
            for (int k = 0; k < len; k++) tr_q.push_back(ev(1, !pitched, div, idx, 0));
            for (int k = 0; k < GAP; k++) tr_q.push_back(ev(1, 1, div, idx, 0));
            if (idx == DEPTH - 1) begin
                wrapped = 1;
                idx = 0;
            end else begin
                idx++;
            end
        end
        while (tr_q.size() > limit) void'(tr_q.pop_back());
    endfunction

    always @(posedge inclk) begin
        logic [EW-1:0] e;
        logic [EW-1:0] a;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {playing, div_reset, div_count, note_idx, done};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL %s vec %0d (state %s): got play=%0b rst=%0b div=%0d idx=%0d done=%0b, want play=%0b rst=%0b div=%0d idx=%0d done=%0b",
                         cur_test, vectors, dbg_state.name(), a[37], a[36], a[35:4], a[3:1], a[0],
                         e[37], e[36], e[35:4], e[3:1], e[0]);
            end
        end
    end

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() > 0; c++) @(negedge inclk);
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL %s timeout: %0d expected words left, want 0", cur_test, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic write_all();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge inclk);
            wr_en = 1'b1;
            wr_addr = AW'(i);
            wr_data = tbl_m[i];
        end
        @(negedge inclk);
        wr_en = 1'b0;
    endtask

    task automatic fill_end();
        for (int i = 0; i < DEPTH; i++) tbl_m[i] = 8'hF0;
    endtask

    // abort_kind: 0 none, 1 stop, 2 reset, asserted so it is sampled at trace word abort_at.
    task automatic run_play(input string name, input bit lp, input int abort_kind,
                            input int abort_at, input int extra_start_at, input int wr_at,
                            input logic [AW-1:0] wr_a, input logic [7:0] wr_d);
        logic [EW-1:0] last;
        cur_test = name;
        build_trace(lp, (abort_kind != 0) ? abort_at : 1_000_000);
        if (abort_kind != 0) begin
            last = tr_q[$];
            for (int k = 0; k < 2; k++) begin
                if (abort_kind == 1) tr_q.push_back(ev(0, 1, last[35:4], int'(last[3:1]), 0));
                else tr_q.push_back(ev(0, 1, 32'd0, 0, 0));
            end
        end
        last = tr_q[$];
        m_div = last[35:4];
        m_idx = int'(last[3:1]);
        @(negedge inclk);
        loop_en = lp;
        start = 1'b1;
        foreach (tr_q[k]) exp_q.push_back(tr_q[k]);
        for (int c = 1; c <= 4000 && exp_q.size() > 0; c++) begin
            @(negedge inclk);
            start   = (c == extra_start_at);
            stop    = (abort_kind == 1 && c == abort_at);
            reset   = (abort_kind == 2 && c == abort_at);
            wr_en   = (c == wr_at);
            wr_addr = wr_a;
            wr_data = wr_d;
        end
        wait_drain(1);
        start = 1'b0;
        stop = 1'b0;
        reset = 1'b0;
        wr_en = 1'b0;
        loop_en = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge inclk);
        exp_q.push_back(ev(0, 1, 32'd0, 0, 0));
        exp_q.push_back(ev(0, 1, 32'd0, 0, 0));
        repeat (2) @(negedge inclk);
        reset = 1'b0;
        wait_drain(10);

        fill_end();
        tbl_m[0] = {NOTE_A4, 4'd2};
        tbl_m[1] = {NOTE_C5, 4'd1};
        write_all();
        run_play("a4_c5_end", 0, 0, 0, 0, 0, '0, '0);

        fill_end();
        tbl_m[0] = {NOTE_REST, 4'd3};
        write_all();
        run_play("rest3", 0, 0, 0, 0, 0, '0, '0);

        fill_end();
        tbl_m[0] = {NOTE_E4, 4'd1};
        write_all();
        run_play("loop_e4_stop", 1, 1, 40, 0, 0, '0, '0);

        fill_end();
        tbl_m[0] = {NOTE_G4, 4'd0};
        write_all();
        run_play("g4_beats0", 0, 0, 0, 0, 0, '0, '0);

        for (int i = 0; i < DEPTH; i++) tbl_m[i] = {4'($urandom_range(1, 8)), 4'd1};
        write_all();
        run_play("all_pitched_wrap", 0, 0, 0, 0, 0, '0, '0);

        fill_end();
        tbl_m[0] = {NOTE_C4, 4'd1};
        tbl_m[1] = {NOTE_D4, 4'd1};
        write_all();
        tbl_m[1] = {NOTE_B4, 4'd2};
        run_play("write_during_tone", 0, 0, 0, 0, 5, 3'd1, {NOTE_B4, 4'd2});

        cur_test = "start_and_stop";
        @(negedge inclk);
        start = 1'b1;
        stop = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back(ev(0, 1, m_div, m_idx, 0));
        @(negedge inclk);
        start = 1'b0;
        stop = 1'b0;
        wait_drain(10);

        fill_end();
        tbl_m[0] = {NOTE_A4, 4'd2};
        tbl_m[1] = {NOTE_F4, 4'd1};
        write_all();
        run_play("start_while_playing", 0, 0, 0, 8, 0, '0, '0);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++)
                tbl_m[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 2))};
            write_all();
            run_play($sformatf("random_%0d", r), 0, 0, 0, 0, 0, '0, '0);
        end

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < DEPTH; i++)
                tbl_m[i] = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 2))};
            write_all();
            run_play($sformatf("random_loop_%0d", r), 1, 1, int'($urandom_range(2, 60)),
                     0, 0, '0, '0);
        end

        fill_end();
        tbl_m[0] = {NOTE_A4, 4'd2};
        write_all();
        run_play("reset_mid_tone", 0, 2, 10, 0, 0, '0, '0);

        repeat (2) @(negedge inclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
